// File: rtl/fft_scale_ctrl_if.sv
// Handshake and status bundle between the FFT datapath and its
// block-floating-point scaling controller.
interface fft_scale_ctrl_if #(
  parameter int WIDTH = 14,
  parameter int LOG2N = 6,
  parameter int EXP_W = 4
);
  logic                    start;
  logic                    in_valid;
  logic signed [WIDTH:0]   in_re;
  logic signed [WIDTH:0]   in_im;
  logic                    scale_en;
  logic [LOG2N-1:0]        stage_idx;
  logic                    stage_done;
  logic                    busy;
  logic                    done;
  logic [EXP_W-1:0]        exponent;
  logic                    proto_err;

  // Datapath side: launches transforms and streams butterfly outputs.
  modport master (
    output start, in_valid, in_re, in_im,
    input  scale_en, stage_idx, stage_done, busy, done, exponent, proto_err
  );

  // Controller side.
  modport slave (
    input  start, in_valid, in_re, in_im,
    output scale_en, stage_idx, stage_done, busy, done, exponent, proto_err
  );
endinterface

// File: rtl/fft_scale_ctrl.sv
// Block-floating-point scaling controller: walks one FFT transform stage by
// stage, watches the pre-rounding butterfly outputs for headroom loss and
// decides whether the next stage's rounding halves its values. The number of
// halved stages is accumulated as the block exponent.
module fft_scale_ctrl #(
  parameter int WIDTH       = 14,
  parameter int LOG2N       = 6,
  parameter int EXP_W       = 4,
  parameter bit FIRST_SCALE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  fft_scale_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STAGE_END = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  localparam logic [LOG2N-1:0] CNT_LAST   = {LOG2N{1'b1}};
  localparam logic [LOG2N-1:0] STAGE_LAST = LOG2N'(LOG2N - 1);
  localparam int               HOT_LIM    = 2 ** (WIDTH - 2);
  // A value is "hot" when its top three bits disagree, i.e. it has left the
  // range [-2^(WIDTH-2), 2^(WIDTH-2)-1]; expressed as a signed range test.
  localparam logic signed [WIDTH:0] HOT_POS = (WIDTH + 1)'(HOT_LIM);
  localparam logic signed [WIDTH:0] HOT_NEG = (WIDTH + 1)'(-HOT_LIM);

  function automatic logic is_hot(input logic signed [WIDTH:0] x);
    return (x >= HOT_POS) || (x < HOT_NEG);
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [LOG2N-1:0]   cnt_r;
  logic [LOG2N-1:0]   stage_r;
  logic               hot_r;
  logic               scale_r;
  logic [EXP_W-1:0]   exp_r;
  logic               perr_r;
  logic               busy_r;
  logic               stage_done_r;
  logic               done_r;

  logic               start_ok_s;
  logic               take_s;
  logic               proto_hit_s;
  logic               sample_hot_s;

  // Next-state decode plus per-cycle qualifiers (accepted start, counted
  // sample, sample arriving while no stage is collecting).
  always_comb begin
    state_nxt_s  = state_r;
    start_ok_s   = 1'b0;
    take_s       = 1'b0;
    proto_hit_s  = 1'b0;
    sample_hot_s = is_hot(bus.in_re) || is_hot(bus.in_im);
    case (state_r)
      ST_IDLE: begin
        proto_hit_s = bus.in_valid;
        if (bus.start) begin
          state_nxt_s = ST_RUN;
          start_ok_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        take_s = bus.in_valid;
        if (bus.in_valid && (cnt_r == CNT_LAST)) begin
          state_nxt_s = ST_STAGE_END;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_STAGE_END: begin
        proto_hit_s = bus.in_valid;
        if (stage_r == STAGE_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        proto_hit_s = bus.in_valid;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Stage bookkeeping: sample count, sticky hot flag, scale decision,
  // stage index and accumulated exponent.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= {LOG2N{1'b0}};
      stage_r <= {LOG2N{1'b0}};
      hot_r   <= 1'b0;
      scale_r <= 1'b0;
      exp_r   <= {EXP_W{1'b0}};
    end else if (start_ok_s) begin
      cnt_r   <= {LOG2N{1'b0}};
      stage_r <= {LOG2N{1'b0}};
      hot_r   <= 1'b0;
      scale_r <= FIRST_SCALE;
      exp_r   <= {EXP_W{1'b0}};
    end else if (take_s) begin
      // Count wraps from N-1 back to 0 on the stage's last sample.
      cnt_r <= cnt_r + LOG2N'(1);
      hot_r <= hot_r | sample_hot_s;
    end else if (state_r == ST_STAGE_END) begin
      // EXP_W is sized so this sum cannot wrap over a full transform.
      exp_r <= exp_r + {{(EXP_W - 1){1'b0}}, scale_r};
      if (stage_r != STAGE_LAST) begin
        stage_r <= stage_r + LOG2N'(1);
        scale_r <= hot_r;
        hot_r   <= 1'b0;
      end else begin
        // Final stage: decisions and index stay visible until next start.
        stage_r <= stage_r;
        scale_r <= scale_r;
        hot_r   <= hot_r;
      end
    end else begin
      cnt_r   <= cnt_r;
      stage_r <= stage_r;
      hot_r   <= hot_r;
      scale_r <= scale_r;
      exp_r   <= exp_r;
    end
  end

  // Sticky protocol error: set by a sample outside RUN, cleared by a start.
  always_ff @(posedge clk) begin
    if (rst) begin
      perr_r <= 1'b0;
    end else if (start_ok_s) begin
      perr_r <= 1'b0;
    end else if (proto_hit_s) begin
      perr_r <= 1'b1;
    end else begin
      perr_r <= perr_r;
    end
  end

  // Status flags registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r       <= 1'b0;
      stage_done_r <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      busy_r       <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_STAGE_END);
      stage_done_r <= (state_nxt_s == ST_STAGE_END);
      done_r       <= (state_nxt_s == ST_DONE);
    end
  end

  assign bus.scale_en   = scale_r;
  assign bus.stage_idx  = stage_r;
  assign bus.stage_done = stage_done_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.exponent   = exp_r;
  assign bus.proto_err  = perr_r;

endmodule

// File: tb/tb_fft_scale_ctrl.sv
// Directed bench for fft_scale_ctrl with an 8-point, 3-stage transform.
module tb_fft_scale_ctrl;
  localparam int WIDTH = 14;
  localparam int LOG2N = 3;
  localparam int EXP_W = 4;
  localparam int N     = 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fft_scale_ctrl_if #(.WIDTH(WIDTH), .LOG2N(LOG2N), .EXP_W(EXP_W)) bus ();

  fft_scale_ctrl #(
    .WIDTH(WIDTH), .LOG2N(LOG2N), .EXP_W(EXP_W), .FIRST_SCALE(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check_val(input string tag, input int obs, input int expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int re, input int im);
    bus.in_valid = v;
    bus.in_re    = (WIDTH + 1)'(re);
    bus.in_im    = (WIDTH + 1)'(im);
  endtask

  task automatic check_reset_state(input string name);
    check_val({name, "/scale_en"},   int'(bus.scale_en),   0);
    check_val({name, "/stage_idx"},  int'(bus.stage_idx),  0);
    check_val({name, "/stage_done"}, int'(bus.stage_done), 0);
    check_val({name, "/busy"},       int'(bus.busy),       0);
    check_val({name, "/done"},       int'(bus.done),       0);
    check_val({name, "/exponent"},   int'(bus.exponent),   0);
    check_val({name, "/proto_err"},  int'(bus.proto_err),  0);
  endtask

  // One full transform. Quiet samples are 4095 / -4096; the sample at
  // (hs, hi) is replaced by (hre, him). lat counts clock edges after the
  // edge that sampled start up to the edge after which done is high.
  task automatic run_xform(input string name, input bit gap,
                           input int hs, input int hi, input int hre, input int him,
                           input bit err_in_stage_end,
                           input bit [2:0] exp_scales, input int exp_exp,
                           input int exp_lat, input int exp_perr);
    int t;
    int guard;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    t = 0;
    check_val({name, "/entry_busy"},  int'(bus.busy),      1);
    check_val({name, "/entry_exp"},   int'(bus.exponent),  0);
    check_val({name, "/entry_perr"},  int'(bus.proto_err), 0);
    for (int s = 0; s < LOG2N; s++) begin
      check_val($sformatf("%s/scale_s%0d", name, s), int'(bus.scale_en), int'(exp_scales[s]));
      check_val($sformatf("%s/stage_idx%0d", name, s), int'(bus.stage_idx), s);
      for (int i = 0; i < N; i++) begin
        if (s == hs && i == hi) drive(1'b1, hre, him);
        else                    drive(1'b1, 4095, -4096);
        tick();
        t++;
        drive(1'b0, 0, 0);
        if (gap && i < N - 1) begin
          tick();
          t++;
        end
      end
      check_val($sformatf("%s/stage_done%0d", name, s), int'(bus.stage_done), 1);
      if (err_in_stage_end) drive(1'b1, 4096, 4096);
      tick();
      t++;
      drive(1'b0, 0, 0);
    end
    guard = 0;
    while (!bus.done && guard < 64) begin
      tick();
      t++;
      guard++;
    end
    check_val({name, "/done_seen"}, int'(bus.done),      1);
    check_val({name, "/latency"},   t,                   exp_lat);
    check_val({name, "/exponent"},  int'(bus.exponent),  exp_exp);
    check_val({name, "/proto_err"}, int'(bus.proto_err), exp_perr);
    tick();
    check_val({name, "/done_pulse"}, int'(bus.done),     0);
    check_val({name, "/idle_busy"},  int'(bus.busy),     0);
    check_val({name, "/exp_held"},   int'(bus.exponent), exp_exp);
    check_val({name, "/last_stage"}, int'(bus.stage_idx), LOG2N - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    drive(1'b0, 0, 0);
    tick();
    tick();
    tick();
    check_reset_state("reset");
    rst = 1'b0;
    tick();

    // Quiet data: only stage 0 scales; 3 stages of 8 samples + 1 end cycle.
    run_xform("quiet", 1'b0, -1, -1, 0, 0, 1'b0, 3'b001, 1, 27, 0);

    // Sample while idle flags a protocol error; the next start clears it.
    drive(1'b1, 4095, -4096);
    tick();
    drive(1'b0, 0, 0);
    check_val("idle_valid/proto_err", int'(bus.proto_err), 1);
    check_val("idle_valid/busy",      int'(bus.busy),      0);

    // Hot imaginary part on the very last sample of stage 0.
    run_xform("hot_last", 1'b0, 0, 7, 4095, 4096, 1'b0, 3'b011, 2, 27, 0);
    // -4097 is just past the negative limit.
    run_xform("neg_hot",  1'b0, 1, 3, -4097, -4096, 1'b0, 3'b101, 2, 27, 0);
    // -4096 is still inside the range.
    run_xform("neg_edge", 1'b0, 1, 3, -4096, -4096, 1'b0, 3'b001, 1, 27, 0);
    // One idle cycle between samples: same decisions, 16 edges per stage.
    run_xform("gapped",   1'b1, 0, 7, 4095, 4096, 1'b0, 3'b011, 2, 48, 0);
    // Hot sample during every STAGE_END: not counted, not hot-checked.
    run_xform("perr",     1'b0, -1, -1, 0, 0, 1'b1, 3'b001, 1, 27, 1);
    // Fresh start clears the sticky error (checked at entry).
    run_xform("clr",      1'b0, -1, -1, 0, 0, 1'b0, 3'b001, 1, 27, 0);

    // Abort with rst at stage 1, sample 3.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < N; i++) begin
      drive(1'b1, 4095, -4096);
      tick();
      drive(1'b0, 0, 0);
    end
    drive(1'b1, 4095, -4096);
    tick();
    drive(1'b0, 0, 0);
    check_val("abort/pre_exp",   int'(bus.exponent),  1);
    check_val("abort/pre_stage", int'(bus.stage_idx), 1);
    check_val("abort/pre_perr",  int'(bus.proto_err), 1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4095, -4096);
      tick();
      drive(1'b0, 0, 0);
    end
    rst = 1'b1;
    drive(1'b1, 4095, -4096);
    tick();
    rst = 1'b0;
    drive(1'b0, 0, 0);
    check_reset_state("abort");
    run_xform("after_rst", 1'b0, -1, -1, 0, 0, 1'b0, 3'b001, 1, 27, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
